// File: rtl/ccg_sweep_pkg.sv
// Shared types and constants for the exhaustive combinational-circuit sweep controller.
// Holds the sweep FSM encoding and the 16-bit MISR polynomial, seed and step function.
package ccg_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR step: shift left, fold the feedback polynomial, then absorb the data word.
  function automatic logic [15:0] misr_next(input logic [15:0] cur, input logic [15:0] din);
    misr_next = {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/ccg_misr.sv
// 16-bit multiple-input signature register compacting the sampled CUT outputs.
module ccg_misr
  import ccg_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic        shift_en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] sig_r;

  // Signature register: seed load takes priority over a compaction step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r <= 16'h0000;
    end else if (seed_load) begin
      sig_r <= MISR_SEED;
    end else if (shift_en) begin
      sig_r <= misr_next(sig_r, din);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/ccg_sweep_ctrl.sv
// Exhaustive sweep controller: applies every N_IN-bit vector to a CUT, compacts the outputs
// into a MISR and counts ones per output. Optional truth-table capture under CCG_SWEEP_TT_EN.
module ccg_sweep_ctrl
  import ccg_sweep_pkg::*;
#(
  parameter int N_IN   = 7,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic [N_IN-1:0]            cut_x,
  input  logic [N_OUT-1:0]           cut_f,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                sig,
  output logic [N_OUT*(N_IN+1)-1:0]  ones_cnt
`ifdef CCG_SWEEP_TT_EN
  ,
  input  logic [N_IN-1:0]            tt_addr,
  output logic [N_OUT-1:0]           tt_data
`endif
);

  localparam int              CW       = N_IN + 1;
  localparam logic [N_IN-1:0] X_MAX    = '1;
  localparam logic [3:0]      SETTLE_V = 4'(SETTLE);

  sweep_state_e                state_r, state_s;
  logic [3:0]                  cnt_r, cnt_s;
  logic [N_IN-1:0]             x_r, x_s;
  logic                        busy_r, done_r;
  logic [N_OUT-1:0][CW-1:0]    ones_r;
  logic                        seed_load_s, sample_s;

  // Next-state, settle counter and stimulus decode.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    x_s         = x_r;
    seed_load_s = 1'b0;
    sample_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_s     = ST_SETTLE;
          cnt_s       = SETTLE_V;
          x_s         = '0;
          seed_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          state_s = (cnt_r == 4'd1) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        // An abort here discards the pending sample so all results freeze together.
        if (abort) begin
          state_s = ST_IDLE;
        end else if (x_r == X_MAX) begin
          sample_s = 1'b1;
          state_s  = ST_DONE;
        end else begin
          sample_s = 1'b1;
          x_s      = x_r + N_IN'(1);
          cnt_s    = SETTLE_V;
          state_s  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM, counter, stimulus and status flags; flags track the next state so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      x_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      x_r     <= x_s;
      busy_r  <= (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Per-output ones counters; N_IN+1 bits hold the full 2^N_IN count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_r <= '0;
    end else if (seed_load_s) begin
      ones_r <= '0;
    end else if (sample_s) begin
      for (int k = 0; k < N_OUT; k++) begin
        ones_r[k] <= ones_r[k] + CW'(cut_f[k]);
      end
    end else begin
      ones_r <= ones_r;
    end
  end

  ccg_misr u_misr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load_s),
    .shift_en  (sample_s),
    .din       (16'(cut_f)),
    .sig       (sig)
  );

`ifdef CCG_SWEEP_TT_EN
  logic [N_OUT-1:0] tt_mem_r [2**N_IN];
  logic [N_OUT-1:0] tt_data_r;

  // Truth-table capture at each sample and registered read port; not touched by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**N_IN; i++) begin
        tt_mem_r[i] <= '0;
      end
      tt_data_r <= '0;
    end else begin
      if (sample_s) begin
        tt_mem_r[x_r] <= cut_f;
      end else begin
        tt_mem_r[x_r] <= tt_mem_r[x_r];
      end
      tt_data_r <= tt_mem_r[tt_addr];
    end
  end

  assign tt_data = tt_data_r;
`endif

  assign cut_x    = x_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign ones_cnt = ones_r;

endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// Directed self-checking bench for ccg_sweep_ctrl at default parameters (CCG_SWEEP_TT_EN optional).
module tb_ccg_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [6:0]  cut_x;
  logic [1:0]  cut_f;
  logic        busy;
  logic        done;
  logic [15:0] sig;
  logic [15:0] ones_cnt;
`ifdef CCG_SWEEP_TT_EN
  logic [6:0]  tt_addr;
  logic [1:0]  tt_data;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mode = 0;
  int lat;
  logic [15:0] exp_sig;
  logic [15:0] exp_ones;

  always #5 clk = ~clk;

  ccg_sweep_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cut_x    (cut_x),
    .cut_f    (cut_f),
    .busy     (busy),
    .done     (done),
    .sig      (sig),
    .ones_cnt (ones_cnt)
`ifdef CCG_SWEEP_TT_EN
    ,
    .tt_addr  (tt_addr),
    .tt_data  (tt_data)
`endif
  );

  // Combinational CUT stand-ins selected per test.
  function automatic logic [1:0] cut_fn(input int m, input logic [6:0] x);
    case (m)
      0:       cut_fn = {&x, ^x};
      1:       cut_fn = 2'b00;
      2:       cut_fn = x[1:0];
      default: cut_fn = 2'b00;
    endcase
  endfunction

  always_comb cut_f = cut_fn(mode, cut_x);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden signature/ones counts after the first nsamp vectors of a sweep.
  task automatic golden(input int m, input int nsamp, output logic [15:0] s, output logic [15:0] ones);
    logic [1:0] f;
    int c0, c1;
    s = 16'hFFFF; c0 = 0; c1 = 0;
    for (int i = 0; i < nsamp; i++) begin
      f  = cut_fn(m, 7'(i));
      s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {14'b0, f};
      c0 += int'(f[0]);
      c1 += int'(f[1]);
    end
    ones = {8'(c1), 8'(c0)};
  endtask

  // Counts negedges after the accepting posedge until done; -1 on timeout.
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
`ifdef CCG_SWEEP_TT_EN
    tt_addr = 7'h00;
`endif
    repeat (3) @(negedge clk);
    check("rst_cut_x", 32'(cut_x), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sig", 32'(sig), 32'h0);
    check("rst_ones", 32'(ones_cnt), 32'h0);

    // Full sweep started in the first cycle after reset release.
    mode = 0;
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(400, lat);
    check("sweep0_latency", 32'(lat), 32'd257);
    check("sweep0_ones", 32'(ones_cnt), 32'h0140);
    golden(0, 128, exp_sig, exp_ones);
    check("sweep0_sig", 32'(sig), 32'(exp_sig));
    check("sweep0_cut_x_hold", 32'(cut_x), 32'h7F);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'h0);
    check("idle_not_busy", 32'(busy), 32'h0);

    // All-zero CUT response.
    mode = 1;
    pulse_start();
    wait_done(400, lat);
    check("zero_latency", 32'(lat), 32'd257);
    golden(1, 128, exp_sig, exp_ones);
    check("zero_sig", 32'(sig), 32'(exp_sig));
    check("zero_ones", 32'(ones_cnt), 32'h0);

    // Abort at t+50: IDLE at t+51 with partial results frozen.
    mode = 0;
    pulse_start();
    for (int k = 1; k < 50; k++) @(negedge clk);
    check("abort_pre_cut_x", 32'(cut_x), 32'd24);
    check("abort_pre_busy", 32'(busy), 32'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'h0);
    check("abort_cut_x", 32'(cut_x), 32'd24);
    check("abort_ones", 32'(ones_cnt), 32'h000C);
    golden(0, 24, exp_sig, exp_ones);
    check("abort_sig", 32'(sig), 32'(exp_sig));
    wait_done(300, lat);
    check("abort_no_done", 32'(lat), 32'hFFFFFFFF);
    check("abort_cut_x_frozen", 32'(cut_x), 32'd24);

    // abort wins over start in IDLE.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check("abort_wins_cut_x", 32'(cut_x), 32'd24);

    // Asynchronous reset mid-sweep, then a clean sweep.
    pulse_start();
    for (int k = 1; k < 100; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cut_x", 32'(cut_x), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_sig", 32'(sig), 32'h0);
    check("midrst_ones", 32'(ones_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(400, lat);
    check("post_rst_latency", 32'(lat), 32'd257);
    check("post_rst_ones", 32'(ones_cnt), 32'h0140);
    golden(0, 128, exp_sig, exp_ones);
    check("post_rst_sig", 32'(sig), 32'(exp_sig));

    // start held high: back-to-back sweeps every 258 cycles.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    wait_done(400, lat);
    check("b2b_first", 32'(lat), 32'd257);
    wait_done(400, lat);
    check("b2b_period", 32'(lat), 32'd258);
    check("b2b_ones", 32'(ones_cnt), 32'h0140);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_stop_idle", 32'(busy), 32'h0);

`ifdef CCG_SWEEP_TT_EN
    // Truth-table capture with cut_f = cut_x[1:0].
    mode = 2;
    pulse_start();
    wait_done(400, lat);
    check("tt_latency", 32'(lat), 32'd257);
    tt_addr = 7'h55;
    @(negedge clk);
    check("tt_0x55", 32'(tt_data), 32'h1);
    tt_addr = 7'h7F;
    @(negedge clk);
    check("tt_0x7f", 32'(tt_data), 32'h3);
    tt_addr = 7'h02;
    @(negedge clk);
    check("tt_0x02", 32'(tt_data), 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
